control_mascota_fsm: RTL and testbench

CONTROL_MASCOTA_FSM -- requirements
Module: control_mascota_fsm

---
 rtl/control_mascota_fsm.sv | 259 +++++++++++++++++++++++++
 tb/tb_control_mascota_fsm.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_mascota_fsm.sv
// control_mascota_fsm
// Virtual pet controller. Five debounced toggle inputs are turned into
// one-cycle events. These events, a free-running tick and a slower decay step
// drive the pet state and its energy and health levels.
//
// Ports
//   clk                 system clock, rising-edge active
//   reset               asynchronous, active-low reset
//   Senal_Test          toggle: flips modo_test (accepted in every state)
//   Senal_Energia       toggle: energia +1 (ACTIVO, JUGANDO, ENFERMO)
//   Senal_Medicina      toggle: salud +1 (any state but MUERTO)
//   Senal_fot           toggle: ACTIVO <-> DORMIDO
//   Senal_ultrasonido   toggle: ACTIVO -> JUGANDO, costs one energia
//   estado[2:0]         ACTIVO=0 DORMIDO=1 JUGANDO=2 ENFERMO=3 MUERTO=4
//   nivel_energia[2:0]  0..5
//   nivel_salud[2:0]    0..5
//   modo_test           1 selects the accelerated tick period
//   tick                one-cycle pulse, high in the cycle the tick's effects become visible
//   evento              one-cycle pulse when at least one event was accepted
module control_mascota_fsm #(
    parameter int TICK_CYCLES      = 50000000,
    parameter int TICK_CYCLES_TEST = 5000000,
    parameter int DECAY_TICKS      = 10,
    parameter int JUEGO_TICKS      = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Senal_Test,
    input  logic       Senal_Energia,
    input  logic       Senal_Medicina,
    input  logic       Senal_fot,
    input  logic       Senal_ultrasonido,
    output logic [2:0] estado,
    output logic [2:0] nivel_energia,
    output logic [2:0] nivel_salud,
    output logic       modo_test,
    output logic       tick,
    output logic       evento
);

    typedef enum logic [2:0] {
        ACTIVO  = 3'd0,
        DORMIDO = 3'd1,
        JUGANDO = 3'd2,
        ENFERMO = 3'd3,
        MUERTO  = 3'd4
    } estado_e;

    localparam int TICK_MAX = (TICK_CYCLES > TICK_CYCLES_TEST) ? TICK_CYCLES : TICK_CYCLES_TEST;
    localparam int CNT_W    = $clog2(TICK_MAX + 1);
    localparam int DEC_W    = $clog2(DECAY_TICKS + 1);
    localparam int PLAY_W   = $clog2(JUEGO_TICKS + 1);

    localparam logic [CNT_W-1:0]  LAST_NORM = CNT_W'(TICK_CYCLES - 1);
    localparam logic [CNT_W-1:0]  LAST_TEST = CNT_W'(TICK_CYCLES_TEST - 1);
    localparam logic [DEC_W-1:0]  LAST_DEC  = DEC_W'(DECAY_TICKS - 1);
    localparam logic [PLAY_W-1:0] LAST_PLAY = PLAY_W'(JUEGO_TICKS - 1);

    // Bit positions of the five event sources inside the packed vectors.
    localparam int EV_TEST = 0;
    localparam int EV_ENER = 1;
    localparam int EV_MED  = 2;
    localparam int EV_FOT  = 3;
    localparam int EV_ULT  = 4;

    // Signed sum of the level and its same-cycle contributions, clamped to 0..5.
    function automatic logic [2:0] clamp_lvl(input logic signed [4:0] v);
        logic [2:0] r;
        if (v < 5'sd0) begin
            r = 3'd0;
        end else if (v > 5'sd5) begin
            r = 3'd5;
        end else begin
            r = v[2:0];
        end
        return r;
    endfunction

    logic [4:0]        senal_s;
    logic [4:0]        sync1_q, sync2_q, prev_q;
    logic [4:0]        ev_s;
    logic [1:0]        arm_q, arm_d;
    logic              armed_s;
    logic [CNT_W-1:0]  tick_cnt_q, tick_cnt_d, tick_last_s;
    logic [DEC_W-1:0]  dec_cnt_q, dec_cnt_d;
    logic [PLAY_W-1:0] play_cnt_q, play_cnt_d;
    logic              tick_s, decay_s, play_done_s;
    logic              acc_test_s, acc_ener_s, acc_med_s, acc_fot_s, acc_ult_s;
    logic signed [4:0] e_sum_s, s_sum_s;
    logic [2:0]        energia_q, energia_d, salud_q, salud_d;
    logic              modo_q, modo_d, tick_q, tick_d, evento_q, evento_d;
    estado_e           estado_q, estado_d;

    assign senal_s = {Senal_ultrasonido, Senal_fot, Senal_Medicina, Senal_Energia, Senal_Test};

    // Event acceptance, counters and level arithmetic for the coming edge.
    always_comb begin
        armed_s = (arm_q == 2'd3);
        arm_d   = armed_s ? 2'd3 : (arm_q + 2'd1);
        // prev_q keeps following sync2_q while unarmed, so toggles seen during arming are lost.
        ev_s    = armed_s ? (sync2_q ^ prev_q) : 5'b00000;

        acc_test_s = ev_s[EV_TEST];
        acc_ener_s = ev_s[EV_ENER] &&
                     ((estado_q == ACTIVO) || (estado_q == JUGANDO) || (estado_q == ENFERMO));
        acc_med_s  = ev_s[EV_MED] && (estado_q != MUERTO);
        acc_fot_s  = ev_s[EV_FOT] && ((estado_q == ACTIVO) || (estado_q == DORMIDO));
        // fot has priority, so a coincident ult is dropped rather than queued.
        acc_ult_s  = ev_s[EV_ULT] && (estado_q == ACTIVO) && (energia_q != 3'd0) && !acc_fot_s;

        tick_last_s = modo_q ? LAST_TEST : LAST_NORM;
        tick_s      = (tick_cnt_q >= tick_last_s);
        if (acc_test_s || tick_s) begin
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_q + CNT_W'(1);
        end

        decay_s   = 1'b0;
        dec_cnt_d = dec_cnt_q;
        if (tick_s) begin
            if (dec_cnt_q >= LAST_DEC) begin
                dec_cnt_d = '0;
                decay_s   = (estado_q != MUERTO);
            end else begin
                dec_cnt_d = dec_cnt_q + DEC_W'(1);
            end
        end else begin
            dec_cnt_d = dec_cnt_q;
        end

        play_done_s = 1'b0;
        play_cnt_d  = play_cnt_q;
        if (acc_ult_s) begin
            play_cnt_d = '0;
        end else if (tick_s && (estado_q == JUGANDO)) begin
            if (play_cnt_q >= LAST_PLAY) begin
                play_cnt_d  = '0;
                play_done_s = 1'b1;
            end else begin
                play_cnt_d = play_cnt_q + PLAY_W'(1);
            end
        end else begin
            play_cnt_d = play_cnt_q;
        end

        e_sum_s = $signed({2'b00, energia_q});
        s_sum_s = $signed({2'b00, salud_q});
        if (acc_ener_s) begin
            e_sum_s = e_sum_s + 5'sd1;
        end else begin
            e_sum_s = e_sum_s;
        end
        if (acc_ult_s) begin
            e_sum_s = e_sum_s - 5'sd1;
        end else begin
            e_sum_s = e_sum_s;
        end
        if (acc_med_s) begin
            s_sum_s = s_sum_s + 5'sd1;
        end else begin
            s_sum_s = s_sum_s;
        end
        if (decay_s) begin
            e_sum_s = (estado_q == DORMIDO) ? (e_sum_s + 5'sd1) : (e_sum_s - 5'sd1);
            // Starvation is judged on the energy held before this step.
            s_sum_s = (energia_q == 3'd0) ? (s_sum_s - 5'sd1) : s_sum_s;
        end else begin
            e_sum_s = e_sum_s;
        end
        energia_d = clamp_lvl(e_sum_s);
        salud_d   = clamp_lvl(s_sum_s);

        modo_d   = modo_q ^ acc_test_s;
        tick_d   = tick_s;
        evento_d = acc_test_s || acc_ener_s || acc_med_s || acc_fot_s || acc_ult_s;
    end

    // Next-state logic; health-driven transitions outrank event-driven ones.
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            ACTIVO, DORMIDO, JUGANDO, ENFERMO: begin
                if (salud_d == 3'd0) begin
                    estado_d = MUERTO;
                end else if (((estado_q == ACTIVO) || (estado_q == JUGANDO)) && (salud_d <= 3'd1)) begin
                    estado_d = ENFERMO;
                end else if ((estado_q == ENFERMO) && (salud_d >= 3'd3)) begin
                    estado_d = ACTIVO;
                end else if (acc_fot_s) begin
                    estado_d = (estado_q == ACTIVO) ? DORMIDO : ACTIVO;
                end else if (acc_ult_s) begin
                    estado_d = JUGANDO;
                end else if (play_done_s) begin
                    estado_d = ACTIVO;
                end else begin
                    estado_d = estado_q;
                end
            end
            MUERTO: begin
                estado_d = MUERTO;
            end
            default: begin
                estado_d = ACTIVO;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q <= ACTIVO;
        end else begin
            estado_q <= estado_d;
        end
    end

    // Synchronizers, counters, levels and registered pulse outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q    <= 5'b00000;
            sync2_q    <= 5'b00000;
            prev_q     <= 5'b00000;
            arm_q      <= 2'd0;
            tick_cnt_q <= '0;
            dec_cnt_q  <= '0;
            play_cnt_q <= '0;
            energia_q  <= 3'd5;
            salud_q    <= 3'd5;
            modo_q     <= 1'b0;
            tick_q     <= 1'b0;
            evento_q   <= 1'b0;
        end else begin
            sync1_q    <= senal_s;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            arm_q      <= arm_d;
            tick_cnt_q <= tick_cnt_d;
            dec_cnt_q  <= dec_cnt_d;
            play_cnt_q <= play_cnt_d;
            energia_q  <= energia_d;
            salud_q    <= salud_d;
            modo_q     <= modo_d;
            tick_q     <= tick_d;
            evento_q   <= evento_d;
        end
    end

    // Outputs come straight from flops.
    always_comb begin
        estado        = estado_q;
        nivel_energia = energia_q;
        nivel_salud   = salud_q;
        modo_test     = modo_q;
        tick          = tick_q;
        evento        = evento_q;
    end

endmodule

// File: tb/tb_control_mascota_fsm.sv
// Self-checking bench for control_mascota_fsm with small tick parameters.
// Expectations are pushed into a time-ordered scoreboard when stimulus is
// applied, and popped and compared on the falling edge of their due cycle.
module tb_control_mascota_fsm;

    logic       clk;
    logic       reset;
    logic       Senal_Test, Senal_Energia, Senal_Medicina, Senal_fot, Senal_ultrasonido;
    logic [2:0] estado, nivel_energia, nivel_salud;
    logic       modo_test, tick, evento;

    localparam int S_ESTADO = 0;
    localparam int S_ENER   = 1;
    localparam int S_SALUD  = 2;
    localparam int S_MODO   = 3;
    localparam int S_TICK   = 4;
    localparam int S_EVENTO = 5;

    typedef struct {
        string tag;
        int    due;
        int    sel;
        int    val;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   base = 0;
    int   checks = 0;
    int   errors = 0;

    control_mascota_fsm #(
        .TICK_CYCLES(4), .TICK_CYCLES_TEST(2), .DECAY_TICKS(2), .JUEGO_TICKS(2)
    ) dut (
        .clk(clk), .reset(reset),
        .Senal_Test(Senal_Test), .Senal_Energia(Senal_Energia),
        .Senal_Medicina(Senal_Medicina), .Senal_fot(Senal_fot),
        .Senal_ultrasonido(Senal_ultrasonido),
        .estado(estado), .nivel_energia(nivel_energia), .nivel_salud(nivel_salud),
        .modo_test(modo_test), .tick(tick), .evento(evento)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int observe(input int sel);
        case (sel)
            S_ESTADO: return int'(estado);
            S_ENER:   return int'(nivel_energia);
            S_SALUD:  return int'(nivel_salud);
            S_MODO:   return int'(modo_test);
            S_TICK:   return int'(tick);
            S_EVENTO: return int'(evento);
            default:  return -1;
        endcase
    endfunction

    // Insert keeping the queue ordered by due cycle.
    task automatic push(input string tag, input int due, input int sel, input int val);
        exp_t e;
        int   idx;
        e.tag = tag; e.due = due; e.sel = sel; e.val = val;
        idx = sb.size();
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].due > due) begin
                idx = i;
                break;
            end
        end
        sb.insert(idx, e);
    endtask

    task automatic exp_rel(input string tag, input int rel, input int sel, input int val);
        push(tag, base + rel, sel, val);
    endtask

    // Advance until `rel` rising edges after reset release, then step off the edge.
    task automatic goto(input int rel);
        while (cyc < base + rel) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        push("rst_estado", cyc + 1, S_ESTADO, 0);
        push("rst_energia", cyc + 1, S_ENER, 5);
        push("rst_salud", cyc + 1, S_SALUD, 5);
        push("rst_modo", cyc + 1, S_MODO, 0);
        push("rst_tick", cyc + 1, S_TICK, 0);
        push("rst_evento", cyc + 1, S_EVENTO, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        base = cyc;
    endtask

    // Scoreboard consumer: compare every expectation that has come due.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            check(e.tag, observe(e.sel), e.val);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        Senal_Test = 1'b0; Senal_Energia = 1'b0; Senal_Medicina = 1'b0;
        Senal_fot = 1'b0; Senal_ultrasonido = 1'b0;

        // A: release with fot already high, then idle ticking and decay.
        Senal_fot = 1'b1;
        do_reset();
        for (int r = 1; r <= 4; r++) exp_rel("a_no_evento", r, S_EVENTO, 0);
        exp_rel("a_estado", 3, S_ESTADO, 0);
        exp_rel("a_estado4", 4, S_ESTADO, 0);
        exp_rel("a_tick3", 3, S_TICK, 0);
        exp_rel("a_tick4", 4, S_TICK, 1);
        exp_rel("a_tick5", 5, S_TICK, 0);
        exp_rel("a_ener7", 7, S_ENER, 5);
        exp_rel("a_ener8", 8, S_ENER, 4);
        exp_rel("a_tick8", 8, S_TICK, 1);
        exp_rel("a_tick12", 12, S_TICK, 1);
        exp_rel("a_ener15", 15, S_ENER, 4);
        exp_rel("a_ener16", 16, S_ENER, 3);
        exp_rel("a_tick16", 16, S_TICK, 1);
        goto(16);

        // B: play, return after two ticks, then reset while playing.
        do_reset();
        goto(2);
        Senal_ultrasonido = ~Senal_ultrasonido;
        exp_rel("b_estado4", 4, S_ESTADO, 0);
        exp_rel("b_ener4", 4, S_ENER, 5);
        exp_rel("b_ev4", 4, S_EVENTO, 0);
        exp_rel("b_estado5", 5, S_ESTADO, 2);
        exp_rel("b_ener5", 5, S_ENER, 4);
        exp_rel("b_ev5", 5, S_EVENTO, 1);
        exp_rel("b_ev6", 6, S_EVENTO, 0);
        exp_rel("b_estado8", 8, S_ESTADO, 2);
        exp_rel("b_ener8", 8, S_ENER, 3);
        exp_rel("b_estado11", 11, S_ESTADO, 2);
        exp_rel("b_estado12", 12, S_ESTADO, 0);
        exp_rel("b_ener12", 12, S_ENER, 3);
        exp_rel("b_ener16", 16, S_ENER, 2);
        goto(17);
        Senal_ultrasonido = ~Senal_ultrasonido;
        exp_rel("b_estado20", 20, S_ESTADO, 2);
        exp_rel("b_ener20", 20, S_ENER, 1);
        goto(21);

        // C: fot and ult together -> sleep only; then wake.
        do_reset();
        goto(2);
        Senal_fot = ~Senal_fot;
        Senal_ultrasonido = ~Senal_ultrasonido;
        exp_rel("c_estado5", 5, S_ESTADO, 1);
        exp_rel("c_ener5", 5, S_ENER, 5);
        exp_rel("c_ev5", 5, S_EVENTO, 1);
        exp_rel("c_ev6", 6, S_EVENTO, 0);
        exp_rel("c_estado6", 6, S_ESTADO, 1);
        exp_rel("c_ener8", 8, S_ENER, 5);
        exp_rel("c_salud8", 8, S_SALUD, 5);
        goto(9);
        Senal_fot = ~Senal_fot;
        exp_rel("c_estado12", 12, S_ESTADO, 0);
        exp_rel("c_ev12", 12, S_EVENTO, 1);
        exp_rel("c_ener16", 16, S_ENER, 4);
        goto(16);

        // D: Energia coincident with a decay step at full energy.
        do_reset();
        goto(5);
        Senal_Energia = ~Senal_Energia;
        exp_rel("d_ener8", 8, S_ENER, 5);
        exp_rel("d_ev8", 8, S_EVENTO, 1);
        exp_rel("d_ener16", 16, S_ENER, 4);
        goto(17);
        Senal_Energia = ~Senal_Energia;
        exp_rel("d_ener20", 20, S_ENER, 5);
        goto(20);

        // E: test mode, starve to sickness, two medicines recover.
        do_reset();
        goto(2);
        Senal_Test = ~Senal_Test;
        exp_rel("e_modo4", 4, S_MODO, 0);
        exp_rel("e_tick4", 4, S_TICK, 1);
        exp_rel("e_modo5", 5, S_MODO, 1);
        exp_rel("e_ev5", 5, S_EVENTO, 1);
        exp_rel("e_tick7", 7, S_TICK, 1);
        exp_rel("e_ener7", 7, S_ENER, 4);
        exp_rel("e_tick8", 8, S_TICK, 0);
        exp_rel("e_tick9", 9, S_TICK, 1);
        exp_rel("e_ener11", 11, S_ENER, 3);
        exp_rel("e_ener23", 23, S_ENER, 0);
        exp_rel("e_salud23", 23, S_SALUD, 5);
        exp_rel("e_salud27", 27, S_SALUD, 4);
        exp_rel("e_estado38", 38, S_ESTADO, 0);
        exp_rel("e_salud38", 38, S_SALUD, 2);
        exp_rel("e_estado39", 39, S_ESTADO, 3);
        exp_rel("e_salud39", 39, S_SALUD, 1);
        goto(37);
        Senal_Medicina = ~Senal_Medicina;
        exp_rel("e_salud40", 40, S_SALUD, 2);
        exp_rel("e_estado40", 40, S_ESTADO, 3);
        exp_rel("e_ev40", 40, S_EVENTO, 1);
        goto(38);
        Senal_Medicina = ~Senal_Medicina;
        exp_rel("e_salud41", 41, S_SALUD, 3);
        exp_rel("e_estado41", 41, S_ESTADO, 0);
        exp_rel("e_ev41", 41, S_EVENTO, 1);
        exp_rel("e_salud43", 43, S_SALUD, 2);
        goto(44);

        // F: starve to death in normal mode; only Test is accepted afterwards.
        do_reset();
        exp_rel("f_ener40", 40, S_ENER, 0);
        exp_rel("f_salud40", 40, S_SALUD, 5);
        exp_rel("f_salud48", 48, S_SALUD, 4);
        exp_rel("f_estado71", 71, S_ESTADO, 0);
        exp_rel("f_estado72", 72, S_ESTADO, 3);
        exp_rel("f_salud72", 72, S_SALUD, 1);
        exp_rel("f_estado79", 79, S_ESTADO, 3);
        exp_rel("f_estado80", 80, S_ESTADO, 4);
        exp_rel("f_salud80", 80, S_SALUD, 0);
        goto(81);
        Senal_Energia = ~Senal_Energia;
        Senal_Medicina = ~Senal_Medicina;
        exp_rel("f_ev84", 84, S_EVENTO, 0);
        exp_rel("f_ener85", 85, S_ENER, 0);
        exp_rel("f_salud85", 85, S_SALUD, 0);
        exp_rel("f_estado85", 85, S_ESTADO, 4);
        goto(85);
        Senal_Test = ~Senal_Test;
        exp_rel("f_modo88", 88, S_MODO, 1);
        exp_rel("f_ev88", 88, S_EVENTO, 1);
        exp_rel("f_estado88", 88, S_ESTADO, 4);
        exp_rel("f_ev89", 89, S_EVENTO, 0);
        exp_rel("f_salud90", 90, S_SALUD, 0);
        exp_rel("f_ener90", 90, S_ENER, 0);
        goto(92);

        @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
